// File: rtl/rv32i_lsu_pkg.sv
// Shared types and constants for the RV32I load/store unit.
package rv32i_lsu_pkg;

    localparam int XLEN = 32;
    localparam int BE_W = 4;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_RESP = 3'd2,
        ST_WB   = 3'd3,
        ST_FIN  = 3'd4
    } lsu_state_e;

    // Stores accept only SB/SH/SW; loads add the unsigned byte/half forms.
    function automatic logic f3_legal(input logic store, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_LB, F3_LH, F3_LW: ok = 1'b1;
            F3_LBU, F3_LHU:      ok = !store;
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/rv32i_lsu_align.sv
// Byte-lane steering: store byte enables/data replication and load lane extract/extension.
module rv32i_lsu_align
    import rv32i_lsu_pkg::*;
(
    input  logic [2:0]      st_funct3_i,
    input  logic [1:0]      st_off_i,
    input  logic [XLEN-1:0] st_data_i,
    output logic [BE_W-1:0] st_be_o,
    output logic [XLEN-1:0] st_wdata_o,
    input  logic [2:0]      ld_funct3_i,
    input  logic [1:0]      ld_off_i,
    input  logic [XLEN-1:0] ld_data_i,
    output logic [XLEN-1:0] ld_val_o
);

    logic [7:0]  ld_byte_s;
    logic [15:0] ld_half_s;

    // Store lanes; misaligned halfwords/words are aligned down by ignoring low offset bits.
    always_comb begin
        st_be_o    = 4'b0000;
        st_wdata_o = 32'h0000_0000;
        case (st_funct3_i)
            F3_SB: begin
                st_be_o    = 4'b0001 << st_off_i;
                st_wdata_o = {4{st_data_i[7:0]}};
            end
            F3_SH: begin
                st_be_o    = 4'b0011 << {st_off_i[1], 1'b0};
                st_wdata_o = {2{st_data_i[15:0]}};
            end
            F3_SW: begin
                st_be_o    = 4'b1111;
                st_wdata_o = st_data_i;
            end
            default: begin
                st_be_o    = 4'b0000;
                st_wdata_o = 32'h0000_0000;
            end
        endcase
    end

    assign ld_byte_s = ld_data_i[{ld_off_i, 3'b000} +: 8];
    assign ld_half_s = ld_data_i[{ld_off_i[1], 4'b0000} +: 16];

    // Load lane extension.
    always_comb begin
        ld_val_o = 32'h0000_0000;
        case (ld_funct3_i)
            F3_LB:   ld_val_o = {{24{ld_byte_s[7]}}, ld_byte_s};
            F3_LH:   ld_val_o = {{16{ld_half_s[15]}}, ld_half_s};
            F3_LW:   ld_val_o = ld_data_i;
            F3_LBU:  ld_val_o = {24'h00_0000, ld_byte_s};
            F3_LHU:  ld_val_o = {16'h0000, ld_half_s};
            default: ld_val_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/rv32i_lsu.sv
// RV32I multi-cycle load/store unit: FSM, bus watchdog and registered outputs.
// Optional RV32I_LSU_MISALIGN_TRAP_EN traps misaligned halfword/word accesses.
module rv32i_lsu
    import rv32i_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] imm,
    input  logic [4:0]      rd,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [BE_W-1:0] mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] wb_data,
    output logic [4:0]      wb_rd,
    output logic            wb_en,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    lsu_state_e      state_q;
    logic [31:0]     cnt_q;
    logic [1:0]      off_q;
    logic [2:0]      f3_q;
    logic            store_q;
    logic            mem_req_q, mem_we_q, wb_en_q, busy_q, done_q, err_q;
    logic [XLEN-1:0] mem_addr_q, mem_wdata_q, wb_data_q;
    logic [BE_W-1:0] mem_be_q;
    logic [4:0]      rd_q;

    logic [XLEN-1:0] ea_s, st_wdata_s, ld_val_s;
    logic [BE_W-1:0] st_be_s;
    logic            trap_s, bad_s, timeout_s;

    assign ea_s = rs1_val + imm;

`ifdef RV32I_LSU_MISALIGN_TRAP_EN
    assign trap_s = ((funct3[1:0] == 2'b01) && ea_s[0]) ||
                    ((funct3[1:0] == 2'b10) && (ea_s[1:0] != 2'b00));
`else
    assign trap_s = 1'b0;
`endif

    assign bad_s     = !f3_legal(is_store, funct3) || trap_s;
    assign timeout_s = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

    rv32i_lsu_align u_align (
        .st_funct3_i (funct3),
        .st_off_i    (ea_s[1:0]),
        .st_data_i   (rs2_val),
        .st_be_o     (st_be_s),
        .st_wdata_o  (st_wdata_s),
        .ld_funct3_i (f3_q),
        .ld_off_i    (off_q),
        .ld_data_i   (mem_rdata),
        .ld_val_o    (ld_val_s)
    );

    // Access sequencer; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 32'd0;
            off_q       <= 2'b00;
            f3_q        <= 3'b000;
            store_q     <= 1'b0;
            rd_q        <= 5'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'd0;
            wb_data_q   <= 32'd0;
            wb_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wb_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        off_q       <= ea_s[1:0];
                        f3_q        <= funct3;
                        store_q     <= is_store;
                        rd_q        <= rd;
                        mem_we_q    <= is_store;
                        mem_addr_q  <= {ea_s[31:2], 2'b00};
                        mem_be_q    <= st_be_s;
                        mem_wdata_q <= st_wdata_s;
                        cnt_q       <= 32'd0;
                        busy_q      <= 1'b1;
                        if (bad_s) begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q   <= ST_REQ;
                            mem_req_q <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    cnt_q <= cnt_q + 32'd1;
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        if (store_q) begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RESP;
                        end
                    end else if (timeout_s) begin
                        mem_req_q <= 1'b0;
                        state_q   <= ST_FIN;
                        done_q    <= 1'b1;
                        err_q     <= 1'b1;
                    end else begin
                        state_q <= ST_REQ;
                    end
                end
                ST_RESP: begin
                    cnt_q <= cnt_q + 32'd1;
                    if (mem_rvalid) begin
                        wb_data_q <= ld_val_s;
                        wb_en_q   <= (rd_q != 5'd0);
                        done_q    <= 1'b1;
                        state_q   <= ST_WB;
                    end else if (timeout_s) begin
                        state_q <= ST_FIN;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        state_q <= ST_RESP;
                    end
                end
                ST_WB, ST_FIN: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    busy_q    <= 1'b0;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_data   = wb_data_q;
    assign wb_rd     = rd_q;
    assign wb_en     = wb_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_rv32i_lsu.sv
// Directed self-checking bench for rv32i_lsu (watchdog shortened to 8 cycles).
module tb_rv32i_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] rs1_val = 32'd0, rs2_val = 32'd0, imm = 32'd0;
    logic [4:0]  rd = 5'd0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_en, busy, done, err;

    int checks = 0;
    int errors = 0;
    int req_cycles;

    rv32i_lsu #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
        .funct3(funct3), .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .rd(rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .wb_data(wb_data), .wb_rd(wb_rd), .wb_en(wb_en),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single sampling edge; returns just after that edge.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] off, input logic [4:0] r);
        is_store = st; funct3 = f3; rs1_val = a; rs2_val = d; imm = off; rd = r;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Zero-wait load: gnt in the first request cycle, rvalid the cycle after.
    task automatic zero_wait_load(input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] off, input logic [4:0] r,
                                  input logic [31:0] rdata);
        issue(1'b0, f3, a, 32'd0, off, r);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdata;
        tick();
        mem_rvalid = 1'b0;
    endtask

    initial begin
        #2;
        check_eq("rst_req",  {31'd0, mem_req}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_addr", mem_addr, 32'd0);
        #20 rst_n = 1'b1;
        tick();

        // LW 0x1000+4
        issue(1'b0, 3'b010, 32'h0000_1000, 32'd0, 32'd4, 5'd5);
        check_eq("lw_req",  {31'd0, mem_req}, 32'd1);
        check_eq("lw_we",   {31'd0, mem_we}, 32'd0);
        check_eq("lw_addr", mem_addr, 32'h0000_1004);
        check_eq("lw_be",   {28'd0, mem_be}, 32'hF);
        check_eq("lw_busy", {31'd0, busy}, 32'd1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        check_eq("lw_req_drop", {31'd0, mem_req}, 32'd0);
        tick();
        mem_rvalid = 1'b0;
        check_eq("lw_wben",  {31'd0, wb_en}, 32'd1);
        check_eq("lw_done",  {31'd0, done}, 32'd1);
        check_eq("lw_err",   {31'd0, err}, 32'd0);
        check_eq("lw_data",  wb_data, 32'hDEAD_BEEF);
        check_eq("lw_rd",    {27'd0, wb_rd}, 32'd5);
        tick();
        check_eq("lw_idle",  {31'd0, busy}, 32'd0);
        check_eq("lw_pulse", {31'd0, done}, 32'd0);

        // LB / LBU at 0x1003
        zero_wait_load(3'b000, 32'h0000_1000, 32'd3, 5'd7, 32'h8011_2233);
        check_eq("lb_data", wb_data, 32'hFFFF_FF80);
        tick();
        zero_wait_load(3'b100, 32'h0000_1004, 32'hFFFF_FFFF, 5'd7, 32'h8011_2233);
        check_eq("lbu_data", wb_data, 32'h0000_0080);
        tick();

        // SB 0x2002 with gnt delayed three cycles
        issue(1'b1, 3'b000, 32'h0000_2000, 32'h0000_00A5, 32'd2, 5'd9);
        check_eq("sb_be",    {28'd0, mem_be}, 32'h4);
        check_eq("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
        check_eq("sb_we",    {31'd0, mem_we}, 32'd1);
        check_eq("sb_addr",  mem_addr, 32'h0000_2000);
        req_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            if (mem_req) req_cycles++;
            mem_gnt = (i == 3);
            tick();
        end
        mem_gnt = 1'b0;
        check_eq("sb_req_cycles", req_cycles, 32'd4);
        check_eq("sb_done", {31'd0, done}, 32'd1);
        check_eq("sb_wben", {31'd0, wb_en}, 32'd0);
        check_eq("sb_req_off", {31'd0, mem_req}, 32'd0);
        tick();
        check_eq("sb_idle", {31'd0, busy}, 32'd0);

        // SH at 0x3002
        issue(1'b1, 3'b001, 32'h0000_3000, 32'hBEEF_1234, 32'd2, 5'd0);
        check_eq("sh_be",    {28'd0, mem_be}, 32'hC);
        check_eq("sh_wdata", mem_wdata, 32'h1234_1234);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check_eq("sh_done", {31'd0, done}, 32'd1);
        tick();

        // LH at ea=0x0001
`ifdef RV32I_LSU_MISALIGN_TRAP_EN
        issue(1'b0, 3'b001, 32'd0, 32'd0, 32'd1, 5'd3);
        check_eq("lh_mis_done", {31'd0, done}, 32'd1);
        check_eq("lh_mis_err",  {31'd0, err}, 32'd1);
        check_eq("lh_mis_req",  {31'd0, mem_req}, 32'd0);
        tick();
`else
        issue(1'b0, 3'b001, 32'd0, 32'd0, 32'd1, 5'd3);
        check_eq("lh_mis_addr", mem_addr, 32'd0);
        check_eq("lh_mis_be",   {28'd0, mem_be}, 32'h3);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_8765;
        tick();
        mem_rvalid = 1'b0;
        check_eq("lh_mis_data", wb_data, 32'hFFFF_8765);
        check_eq("lh_mis_err",  {31'd0, err}, 32'd0);
        tick();
`endif

        // Watchdog: gnt never comes
        issue(1'b0, 3'b010, 32'h0000_4000, 32'd0, 32'd0, 5'd4);
        req_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) break;
            if (mem_req) req_cycles++;
            tick();
        end
        check_eq("to_req_cycles", req_cycles, 32'd8);
        check_eq("to_done", {31'd0, done}, 32'd1);
        check_eq("to_err",  {31'd0, err}, 32'd1);
        check_eq("to_wben", {31'd0, wb_en}, 32'd0);
        tick();
        check_eq("to_idle", {31'd0, busy}, 32'd0);

        // Illegal funct3
        issue(1'b0, 3'b011, 32'h0000_5000, 32'd0, 32'd0, 5'd4);
        check_eq("ill_done", {31'd0, done}, 32'd1);
        check_eq("ill_err",  {31'd0, err}, 32'd1);
        check_eq("ill_req",  {31'd0, mem_req}, 32'd0);
        tick();

        // Reset in RESP, then a late rvalid
        issue(1'b0, 3'b010, 32'h0000_6000, 32'd0, 32'd0, 5'd6);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        rst_n = 1'b0;
        #2;
        check_eq("rst_mid_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_mid_rd",   {27'd0, wb_rd}, 32'd0);
        tick();
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        tick();
        mem_rvalid = 1'b0;
        check_eq("rst_late_wben", {31'd0, wb_en}, 32'd0);
        check_eq("rst_late_done", {31'd0, done}, 32'd0);
        check_eq("rst_late_data", wb_data, 32'd0);
        check_eq("rst_late_addr", mem_addr, 32'd0);

        // LW to x0
        zero_wait_load(3'b010, 32'h0000_7000, 32'd0, 5'd0, 32'h0BAD_F00D);
        check_eq("x0_done", {31'd0, done}, 32'd1);
        check_eq("x0_wben", {31'd0, wb_en}, 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
